// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the memory stage.
package mem_pkg;

   typedef enum logic [1:0] {
      MEM_B = 2'b00,
      MEM_H = 2'b01,
      MEM_W = 2'b10
   } mem_size_t;

   typedef enum logic {
      StIdle,
      StWait
   } stage_m_state_t;

   // Byte enables of an access; unknown size codes behave as a word.
   function automatic logic [3:0] laneMask(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] mask;
      case (mem_size_t'(size))
         MEM_B:   mask = 4'(4'b0001 << off);
         MEM_H:   mask = off[1] ? 4'b1100 : 4'b0011;
         default: mask = 4'b1111;
      endcase
      return mask;
   endfunction

   // Store data replicated across every lane it could land in.
   function automatic logic [31:0] storeLanes(input logic [1:0] size, input logic [31:0] data);
      logic [31:0] lanes;
      case (mem_size_t'(size))
         MEM_B:   lanes = {4{data[7:0]}};
         MEM_H:   lanes = {2{data[15:0]}};
         default: lanes = data;
      endcase
      return lanes;
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      logic bad;
      case (mem_size_t'(size))
         MEM_B:   bad = 1'b0;
         MEM_H:   bad = off[0];
         default: bad = (off != 2'b00);
      endcase
      return bad;
   endfunction

   // Pick the addressed lane out of a RAM word and extend it to 32 bits.
   function automatic logic [31:0] loadExtend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      b = 8'(word >> {off, 3'b000});
      h = off[1] ? word[31:16] : word[15:0];
      case (mem_size_t'(size))
         MEM_B:   res = sgn ? {{24{b[7]}}, b} : {24'h0, b};
         MEM_H:   res = sgn ? {{16{h[15]}}, h} : {16'h0, h};
         default: res = word;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/ram_be.sv
// Word-wide data RAM with byte-enable writes and a registered read port.
module ram_be #(
   parameter int unsigned DEPTH_LOG2 = 13
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic                  re,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [3:0]            be,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   logic [31:0] mem [2**DEPTH_LOG2];

   // Byte-lane write; contents are not affected by reset.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // Read data register, the only state cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= 32'h0;
      end else if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/stage_m_ls.sv
// Memory stage: E/M pipeline register, wait-state FSM, load/store lane handling.
module stage_m_ls
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2  = 13,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ALUResultE,
   input  logic [31:0] WriteDataE,
   input  logic [31:0] PCPlus4E,
   input  logic [4:0]  RdE,
   input  logic        armE,
   input  logic        PCSrcE,
   input  logic        RegWriteE,
   input  logic        MemWriteE,
   input  logic        MemReadE,
   input  logic [1:0]  ResultSrcE,
   input  logic [1:0]  MemSizeE,
   input  logic        MemSignedE,
   input  logic        StallM,
   input  logic        FlushM,
   output logic [31:0] ALUResultM,
   output logic [31:0] PCPlus4M,
   output logic [4:0]  RdM,
   output logic        PCSrcM,
   output logic        RegWriteM,
   output logic        armM,
   output logic [1:0]  ResultSrcM,
   output logic [31:0] ReadDataW,
   output logic        MemBusyM,
   output logic        MisalignM,
   output logic [31:0] WriteData,
   output logic [31:0] DataAddr,
   output logic        MemWrite,
   output logic [3:0]  ByteEn
);

   localparam int unsigned CntW = 3;

   // 2: registered (combined build), 1: ARM-only, 0: RV-only.
`ifdef RISCV
 `ifdef ARM
   localparam int unsigned ArmMode = 2;
 `else
   localparam int unsigned ArmMode = 0;
 `endif
`elsif ARM
   localparam int unsigned ArmMode = 1;
`else
   localparam int unsigned ArmMode = 2;
`endif

   logic [31:0]    writeDataM;
   logic           memWriteM, memReadM, memSignedM, armQ, doneM;
   logic [1:0]     memSizeM;
   stage_m_state_t stateQ, stateD;
   logic [CntW-1:0] cntQ, cntD;
   logic           memOpM, access, complete;
   logic           ramWe, ramRe;
   logic [3:0]     laneBe;
   logic [31:0]    ramRdata;
   logic [1:0]     offQ, sizeQ;
   logic           sgnQ, zeroQ;

   assign memOpM    = memReadM | memWriteM;
   assign MisalignM = memOpM & misaligned(memSizeM, ALUResultM[1:0]);
   // doneM keeps a stalled instruction from being executed a second time.
   assign access    = memOpM & ~MisalignM & ~doneM;

   // E/M register: reset, busy hold, flush bubble, stall hold, load.
   always_ff @(posedge clk) begin
      if (rst) begin
         ALUResultM <= '0; writeDataM <= '0; PCPlus4M   <= '0; RdM       <= '0;
         armQ       <= 1'b0; PCSrcM   <= 1'b0; RegWriteM <= 1'b0; memWriteM <= 1'b0;
         memReadM   <= 1'b0; ResultSrcM <= '0; memSizeM <= '0; memSignedM <= 1'b0;
         doneM      <= 1'b0;
      end else if (MemBusyM) begin
         // access in flight: everything holds
      end else if (FlushM) begin
         ALUResultM <= '0; writeDataM <= '0; PCPlus4M   <= '0; RdM       <= '0;
         armQ       <= 1'b0; PCSrcM   <= 1'b0; RegWriteM <= 1'b0; memWriteM <= 1'b0;
         memReadM   <= 1'b0; ResultSrcM <= '0; memSizeM <= '0; memSignedM <= 1'b0;
         doneM      <= 1'b0;
      end else if (StallM) begin
         if (complete) doneM <= 1'b1;
      end else begin
         ALUResultM <= ALUResultE; writeDataM <= WriteDataE; PCPlus4M <= PCPlus4E;
         RdM        <= RdE;        armQ       <= armE;       PCSrcM   <= PCSrcE;
         RegWriteM  <= RegWriteE;  memWriteM  <= MemWriteE;  memReadM <= MemReadE;
         ResultSrcM <= ResultSrcE; memSizeM   <= MemSizeE;   memSignedM <= MemSignedE;
         doneM      <= 1'b0;
      end
   end

   assign armM = (ArmMode == 2) ? armQ : (ArmMode == 1);

   // FSM state and wait counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ <= StIdle;
         cntQ   <= '0;
      end else begin
         stateQ <= stateD;
         cntQ   <= cntD;
      end
   end

   // FSM next state: enter WAIT for a multi-cycle access, count down to completion.
   always_comb begin
      stateD = stateQ;
      cntD   = cntQ;
      unique case (stateQ)
         StIdle: begin
            if (access && (WAIT_CYCLES != 0)) begin
               stateD = StWait;
               cntD   = CntW'(WAIT_CYCLES - 1);
            end
         end
         StWait: begin
            if (cntQ != '0) cntD = cntQ - 1'b1;
            else            stateD = StIdle;
         end
      endcase
   end

   // FSM outputs: busy until the completion cycle; reset suppresses completion.
   always_comb begin
      MemBusyM = 1'b0;
      complete = 1'b0;
      unique case (stateQ)
         StIdle: begin
            if (access) begin
               if (WAIT_CYCLES == 0) complete = ~rst;
               else                  MemBusyM = 1'b1;
            end
         end
         StWait: begin
            if (cntQ != '0) MemBusyM = 1'b1;
            else            complete = ~rst;
         end
      endcase
   end

   assign laneBe    = laneMask(memSizeM, ALUResultM[1:0]);
   assign ramWe     = complete & memWriteM;
   assign ramRe     = complete & memReadM;
   assign WriteData = storeLanes(memSizeM, writeDataM);
   assign DataAddr  = ALUResultM;
   assign MemWrite  = ramWe;
   assign ByteEn    = ramWe ? laneBe : 4'b0000;

   ram_be #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) uRam (
      .clk  (clk),
      .rst  (rst),
      .we   (ramWe),
      .re   (ramRe),
      .addr (ALUResultM[DEPTH_LOG2+1:2]),
      .be   (laneBe),
      .wdata(WriteData),
      .rdata(ramRdata)
   );

   // Lane selection travels with the read; a misaligned access forces zero data.
   always_ff @(posedge clk) begin
      if (rst) begin
         offQ  <= '0;
         sizeQ <= '0;
         sgnQ  <= 1'b0;
         zeroQ <= 1'b0;
      end else if (ramRe) begin
         offQ  <= ALUResultM[1:0];
         sizeQ <= memSizeM;
         sgnQ  <= memSignedM;
         zeroQ <= 1'b0;
      end else if (MisalignM) begin
         zeroQ <= 1'b1;
      end
   end

   assign ReadDataW = zeroQ ? 32'h0 : loadExtend(ramRdata, sizeQ, offQ, sgnQ);

endmodule

// File: tb/tb_stage_m_ls.sv
// Bench: two instances (0 and 3 wait states) against a byte-array memory model.
module tb_stage_m_ls;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] pc4;
      logic [4:0]  rd;
      logic        arm;
      logic        pcs;
      logic        rw;
      logic        mw;
      logic        mr;
      logic        sgn;
      logic [1:0]  rs;
      logic [1:0]  size;
   } instr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ALUResultE, WriteDataE, PCPlus4E;
   logic [4:0]  RdE;
   logic        armE, PCSrcE, RegWriteE, MemWriteE, MemReadE, MemSignedE, StallM, FlushM;
   logic [1:0]  ResultSrcE, MemSizeE;

   logic [31:0] aluM0, pcM0, rdW0, wd0, da0, aluM3, pcM3, rdW3, wd3, da3;
   logic [4:0]  rdM0, rdM3;
   logic        pcsM0, rwM0, armM0, busy0, mis0, mw0, pcsM3, rwM3, armM3, busy3, mis3, mw3;
   logic [1:0]  rsM0, rsM3;
   logic [3:0]  be0, be3;

   always #5 clk = ~clk;

   stage_m_ls #(.DEPTH_LOG2(6), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
      .PCPlus4E(PCPlus4E), .RdE(RdE), .armE(armE), .PCSrcE(PCSrcE), .RegWriteE(RegWriteE),
      .MemWriteE(MemWriteE), .MemReadE(MemReadE), .ResultSrcE(ResultSrcE),
      .MemSizeE(MemSizeE), .MemSignedE(MemSignedE), .StallM(StallM), .FlushM(FlushM),
      .ALUResultM(aluM0), .PCPlus4M(pcM0), .RdM(rdM0), .PCSrcM(pcsM0), .RegWriteM(rwM0),
      .armM(armM0), .ResultSrcM(rsM0), .ReadDataW(rdW0), .MemBusyM(busy0), .MisalignM(mis0),
      .WriteData(wd0), .DataAddr(da0), .MemWrite(mw0), .ByteEn(be0)
   );

   stage_m_ls #(.DEPTH_LOG2(6), .WAIT_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
      .PCPlus4E(PCPlus4E), .RdE(RdE), .armE(armE), .PCSrcE(PCSrcE), .RegWriteE(RegWriteE),
      .MemWriteE(MemWriteE), .MemReadE(MemReadE), .ResultSrcE(ResultSrcE),
      .MemSizeE(MemSizeE), .MemSignedE(MemSignedE), .StallM(StallM), .FlushM(FlushM),
      .ALUResultM(aluM3), .PCPlus4M(pcM3), .RdM(rdM3), .PCSrcM(pcsM3), .RegWriteM(rwM3),
      .armM(armM3), .ResultSrcM(rsM3), .ReadDataW(rdW3), .MemBusyM(busy3), .MisalignM(mis3),
      .WriteData(wd3), .DataAddr(da3), .MemWrite(mw3), .ByteEn(be3)
   );

   // Model state: one byte array per instance (they diverge after the reset abort test).
   logic [7:0]  mem [2][256];
   logic [31:0] prev [2];
   logic [31:0] newVal [2];
   instr_t      cur;
   int          curS;
   bit          curAcc, curMis, pinOn;
   logic [3:0]  expBe, pinVal;
   logic [31:0] expLanes;
   int          nVec = 0;
   int          nErr = 0;

   task automatic chk(input string nm, input int d, input logic [31:0] act,
                      input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s dut%0d @%0t: got %h, expected %h", nm, (d == 0) ? 0 : 3, $time,
                  act, exp);
      end
   endtask

   function automatic logic [31:0] modelLoad(input int d, input instr_t i);
      int          b;
      logic [15:0] h;
      b = int'(i.addr[7:0]);
      h = {mem[d][b+1], mem[d][b]};
      if (i.size == 2'd0) return i.sgn ? {{24{mem[d][b][7]}}, mem[d][b]} : {24'h0, mem[d][b]};
      if (i.size == 2'd1) return i.sgn ? {{16{h[15]}}, h} : {16'h0, h};
      return {mem[d][b+3], mem[d][b+2], h};
   endfunction

   task automatic modelStore(input int d, input instr_t i);
      int b;
      b = int'(i.addr[7:0]);
      mem[d][b] = i.data[7:0];
      if (i.size != 2'd0) mem[d][b+1] = i.data[15:8];
      if (i.size == 2'd2) begin
         mem[d][b+2] = i.data[23:16];
         mem[d][b+3] = i.data[31:24];
      end
   endtask

   // Expected outputs t cycles after the instruction entered M.
   task automatic checkDut(input int d, input int t, input logic [31:0] aluM,
                           input logic [31:0] pcM, input logic [4:0] rdM, input logic [4:0] ctl,
                           input logic [31:0] rdW, input logic busy, input logic mis,
                           input logic mw, input logic [3:0] be, input logic [31:0] wd,
                           input logic [31:0] da);
      int w, weff, last;
      bit inM, commit;
      w      = (d == 0) ? 0 : 3;
      weff   = curAcc ? w : 0;
      last   = (weff > curS) ? weff : curS;
      inM    = (t <= last);
      commit = curAcc && cur.mw && (t == w);
      chk("ALUResultM", d, aluM, inM ? cur.addr : 32'h0);
      chk("PCPlus4M", d, pcM, inM ? cur.pc4 : 32'h0);
      chk("RdM", d, 32'(rdM), inM ? 32'(cur.rd) : 32'h0);
      chk("ctrlM", d, 32'(ctl), inM ? 32'({cur.pcs, cur.rw, cur.arm, cur.rs}) : 32'h0);
      chk("MemBusyM", d, 32'(busy), 32'(curAcc && (t < w)));
      chk("MisalignM", d, 32'(mis), 32'(inM && curMis));
      chk("MemWrite", d, 32'(mw), 32'(commit));
      chk("ByteEn", d, 32'(be), commit ? 32'(expBe) : 32'h0);
      if (commit) begin
         chk("WriteData", d, wd, expLanes);
         chk("DataAddr", d, da, cur.addr);
         if (pinOn) chk("ByteEnLit", d, 32'(be), 32'(pinVal));
      end
      chk("ReadDataW", d, rdW, (t > weff) ? newVal[d] : prev[d]);
   endtask

   task automatic checkBoth(input int t);
      checkDut(0, t, aluM0, pcM0, rdM0, {pcsM0, rwM0, armM0, rsM0}, rdW0, busy0, mis0, mw0,
               be0, wd0, da0);
      checkDut(1, t, aluM3, pcM3, rdM3, {pcsM3, rwM3, armM3, rsM3}, rdW3, busy3, mis3, mw3,
               be3, wd3, da3);
   endtask

   task automatic driveE(input instr_t i);
      ALUResultE = i.addr; WriteDataE = i.data; PCPlus4E = i.pc4; RdE = i.rd;
      armE = i.arm; PCSrcE = i.pcs; RegWriteE = i.rw; MemWriteE = i.mw; MemReadE = i.mr;
      ResultSrcE = i.rs; MemSizeE = i.size; MemSignedE = i.sgn;
   endtask

   // Expect every output at its idle/reset value.
   task automatic expectIdle();
      cur = '0; curS = 0; curAcc = 0; curMis = 0;
      for (int d = 0; d < 2; d++) begin
         prev[d] = 32'h0; newVal[d] = 32'h0;
      end
      checkBoth(1);
   endtask

   // op: 0 ALU, 1 load, 2 store.
   function automatic instr_t mk(input int op, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] data);
      instr_t i;
      i.addr = addr; i.data = data; i.pc4 = $urandom; i.rd = 5'($urandom);
      i.arm = 1'($urandom); i.pcs = 1'($urandom); i.rw = 1'($urandom); i.rs = 2'($urandom);
      i.mr = (op == 1); i.mw = (op == 2); i.size = size; i.sgn = sgn;
      return i;
   endfunction

   // Issue one instruction, hold it in M with StallM for s cycles, check every cycle.
   task automatic issue(input instr_t i, input int s);
      int tmax;
      bit memop;
      cur    = i;
      curS   = s;
      memop  = i.mr || i.mw;
      curMis = memop && (((i.size == 2'd1) && i.addr[0]) ||
                         ((i.size == 2'd2) && (i.addr[1:0] != 2'b00)));
      curAcc = memop && !curMis;
      expBe  = (i.size == 2'd0) ? 4'(1 << i.addr[1:0]) :
               (i.size == 2'd1) ? 4'(3 << i.addr[1:0]) : 4'hF;
      expLanes = (i.size == 2'd0) ? {4{i.data[7:0]}} :
                 (i.size == 2'd1) ? {2{i.data[15:0]}} : i.data;
      for (int d = 0; d < 2; d++) begin
         if (curAcc && i.mr) newVal[d] = modelLoad(d, i);
         else if (curMis)    newVal[d] = 32'h0;
         else                newVal[d] = prev[d];
      end
      driveE(i);
      StallM = 1'b0;
      @(posedge clk); #1;
      driveE('0);
      tmax = ((s > 3) ? s : 3) + 2;
      for (int t = 0; t <= tmax; t++) begin
         StallM = (t < s);
         @(negedge clk);
         checkBoth(t);
         @(posedge clk); #1;
      end
      StallM = 1'b0;
      if (curAcc && i.mw) begin
         modelStore(0, i);
         modelStore(1, i);
      end
      for (int d = 0; d < 2; d++) prev[d] = newVal[d];
   endtask

   task automatic litChk(input string nm, input logic [31:0] lit);
      chk(nm, 0, rdW0, lit);
      chk(nm, 1, rdW3, lit);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      instr_t ri;
      rst = 1'b1; StallM = 1'b0; FlushM = 1'b0; pinOn = 0; pinVal = 4'h0;
      driveE('0);
      repeat (3) @(posedge clk);
      #1;
      expectIdle();
      rst = 1'b0;
      @(posedge clk); #1;

      // Give every word a known value.
      for (int w = 0; w < 64; w++) issue(mk(2, 2'd2, 1'b0, 32'(w * 4), $urandom), 0);

      issue(mk(2, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF), 0);
      issue(mk(1, 2'd0, 1'b1, 32'h13, 32'h0), 0);
      litChk("LB_signed", 32'hFFFFFFDE);
      issue(mk(1, 2'd0, 1'b0, 32'h13, 32'h0), 0);
      litChk("LBU", 32'h000000DE);
      issue(mk(1, 2'd1, 1'b1, 32'h12, 32'h0), 0);
      litChk("LH_signed", 32'hFFFFDEAD);

      issue(mk(2, 2'd2, 1'b0, 32'h20, 32'h11223344), 0);
      pinOn = 1; pinVal = 4'b0010;
      issue(mk(2, 2'd0, 1'b0, 32'h21, 32'h0000007F), 0);
      pinOn = 0;
      issue(mk(1, 2'd2, 1'b0, 32'h20, 32'h0), 0);
      litChk("SB_merge", 32'h11227F44);

      // Store held in M by the hazard unit must commit once.
      issue(mk(2, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D), 4);
      issue(mk(1, 2'd2, 1'b0, 32'h40, 32'h0), 4);
      litChk("stalled_SW", 32'hCAFEF00D);
      issue(mk(1, 2'd2, 1'b0, 32'h44, 32'h0), 0);

      issue(mk(2, 2'd2, 1'b0, 32'h30, 32'h55667788), 0);
      issue(mk(2, 2'd1, 1'b0, 32'h31, 32'h00001234), 0);
      issue(mk(1, 2'd2, 1'b0, 32'h30, 32'h0), 0);
      litChk("SH_misaligned_nowrite", 32'h55667788);
      issue(mk(1, 2'd2, 1'b0, 32'h32, 32'h0), 0);
      litChk("LW_misaligned", 32'h00000000);

      // Upper address bits alias onto the same word.
      issue(mk(2, 2'd2, 1'b0, 32'h00000150, 32'h0BADC0DE), 0);
      issue(mk(1, 2'd2, 1'b0, 32'h50, 32'h0), 0);
      litChk("alias", 32'h0BADC0DE);

      // Reset during the wait of a store: dut0 already committed, dut3 must not.
      ri = mk(2, 2'd2, 1'b0, 32'h60, 32'hA5A5A5A5);
      driveE(ri);
      @(posedge clk); #1;
      driveE('0);
      @(negedge clk);
      chk("rst_commit_w0", 0, 32'(mw0), 32'h1);
      chk("rst_busy_w3", 1, 32'(busy3), 32'h1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_nowrite", 1, 32'(mw3), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      expectIdle();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("post_rst_write", 1, 32'(mw3), 32'h0);
         chk("post_rst_busy", 1, 32'(busy3), 32'h0);
      end
      @(posedge clk); #1;
      modelStore(0, ri);
      issue(mk(1, 2'd2, 1'b0, 32'h60, 32'h0), 0);
      chk("rst_w0_written", 0, rdW0, 32'hA5A5A5A5);

      for (int n = 0; n < 250; n++) begin
         int          op;
         int          s;
         logic [1:0]  sz;
         logic [31:0] a;
         op = int'($urandom_range(0, 2));
         sz = 2'($urandom_range(0, 2));
         a  = 32'($urandom_range(0, 1023));
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'b00;
         end
         if ($urandom_range(0, 7) == 0) a[31:10] = 22'($urandom);
         s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
         issue(mk(op, sz, 1'($urandom), a, $urandom), s);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
